gpu_command_scheduler: RTL and testbench

//  Queues draw commands (framebuffer fill, triangle) written through the GPU register file, issues them
//  one at a time to the fill engine or triangle rasteriser via start/done handshakes, and builds the

---
 rtl/gpu_command_scheduler_pkg.sv | 35 +++
 rtl/gpu_command_scheduler_if.sv | 37 +++
 rtl/gpu_command_scheduler_fifo.sv | 67 ++++++
 rtl/gpu_command_scheduler.sv | 169 ++++++++++++++++
 tb/tb_gpu_command_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_command_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_cmd_pkg
// Brief   : Shared constants, status bit map and FSM encoding for the GPU
//           command scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package gpu_cmd_pkg;

    localparam logic CMD_FILL = 1'b0;
    localparam logic CMD_TRI  = 1'b1;

    localparam int CMD_WIDTH = 33;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_OVERFLOW  = 1;
    localparam int STATUS_TIMEOUT   = 2;
    localparam int STATUS_SPURIOUS  = 3;
    localparam int STATUS_CUR_TYPE  = 4;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_DONE_LSB  = 16;

    typedef struct packed {
        logic        cmd_type;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_command_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : gpu_command_scheduler_if
// Brief   : Command-write, engine handshake and status signals of the
//           scheduler; slave = scheduler side, master = surrounding logic.
// Revision: 1.0 - initial release
// ============================================================================
interface gpu_command_scheduler_if;

    logic        cmd_write;
    logic        cmd_type;
    logic [31:0] cmd_data;
    logic        cmd_full;
    logic        status_clear;
    logic        fill_start;
    logic [31:0] fill_payload;
    logic        fill_done;
    logic        tri_start;
    logic [31:0] tri_payload;
    logic        tri_done;
    logic [31:0] status_word;
    logic        irq;

    modport master (
        output cmd_write, cmd_type, cmd_data, status_clear, fill_done, tri_done,
        input  cmd_full, fill_start, fill_payload, tri_start, tri_payload,
               status_word, irq
    );

    modport slave (
        input  cmd_write, cmd_type, cmd_data, status_clear, fill_done, tri_done,
        output cmd_full, fill_start, fill_payload, tri_start, tri_payload,
               status_word, irq
    );

endinterface
`default_nettype wire

// File: rtl/gpu_command_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gpu_cmd_fifo
// Brief   : Synchronous FIFO with registered occupancy count; a simultaneous
//           push and pop leaves the count unchanged.
// Revision: 1.0 - initial release
// ============================================================================
module gpu_cmd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           pop_data,
    output logic      [$clog2(DEPTH):0]     count,
    output logic                            full,
    output logic                            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : gpu_command_scheduler
// Brief   : Queues fill/triangle commands, issues them one at a time to the
//           engines with a done timeout, and builds the status word.
// Revision: 1.0 - initial release
// ============================================================================
module gpu_command_scheduler
    import gpu_cmd_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  wire logic               clock,
    input  wire logic               reset,
    gpu_command_scheduler_if.slave  bus
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    cmd_t           w_head;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_nxt;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    logic           r_cur_type;
    logic [31:0]    r_cur_payload;
    logic [TW-1:0]  r_to_cnt;
    logic [TW-1:0]  w_to_cnt_nxt;
    logic [15:0]    r_completed;
    logic [15:0]    w_completed_nxt;
    logic           r_fill_start;
    logic           r_tri_start;
    logic           w_fill_start_nxt;
    logic           w_tri_start_nxt;
    logic           w_complete;
    logic           w_timeout;
    logic           w_spurious;
    logic           w_match_done;
    logic           w_other_done;
    logic [2:0]     r_sticky;
    logic [2:0]     w_sticky_nxt;
    logic           w_overflow;
    logic           w_cur_type_nxt;
    logic           w_busy_nxt;
    logic [31:0]    r_status;
    logic           r_irq;

    // A write seen while the registered count is full is dropped even if a pop lands this cycle.
    assign w_push     = bus.cmd_write & ~w_full;
    assign w_overflow = bus.cmd_write & w_full;

    gpu_cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data ({bus.cmd_type, bus.cmd_data}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pop            = 1'b0;
        w_fill_start_nxt = 1'b0;
        w_tri_start_nxt  = 1'b0;
        w_complete       = 1'b0;
        w_timeout        = 1'b0;
        w_to_cnt_nxt     = r_to_cnt;
        w_match_done     = (r_cur_type == CMD_FILL) ? bus.fill_done : bus.tri_done;
        w_other_done     = (r_cur_type == CMD_FILL) ? bus.tri_done  : bus.fill_done;
        w_spurious       = bus.fill_done | bus.tri_done;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_fill_start_nxt = (r_cur_type == CMD_FILL);
                w_tri_start_nxt  = (r_cur_type == CMD_TRI);
                w_to_cnt_nxt     = '0;
                w_state_nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                w_spurious = w_other_done;
                if (w_match_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt == C_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status is built from next-cycle values so the registered word matches the state it reports.
    assign w_count_nxt     = w_count + CW'(w_push) - CW'(w_pop);
    assign w_cur_type_nxt  = w_pop ? w_head.cmd_type : r_cur_type;
    assign w_completed_nxt = r_completed + 16'(w_complete);
    assign w_busy_nxt      = (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
    assign w_sticky_nxt    = (bus.status_clear ? 3'b000 : r_sticky)
                           | {w_spurious, w_timeout, w_overflow};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur_type    <= CMD_FILL;
            r_cur_payload <= '0;
            r_to_cnt      <= '0;
            r_completed   <= '0;
            r_fill_start  <= 1'b0;
            r_tri_start   <= 1'b0;
            r_sticky      <= '0;
            r_status      <= '0;
            r_irq         <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cur_type    <= w_head.cmd_type;
                r_cur_payload <= w_head.data;
            end
            r_to_cnt     <= w_to_cnt_nxt;
            r_completed  <= w_completed_nxt;
            r_fill_start <= w_fill_start_nxt;
            r_tri_start  <= w_tri_start_nxt;
            r_sticky     <= w_sticky_nxt;
            r_irq        <= |w_sticky_nxt;
            r_status     <= {w_completed_nxt, 8'(w_count_nxt), 3'b000,
                             w_cur_type_nxt, w_sticky_nxt, w_busy_nxt};
        end
    end

    assign bus.cmd_full     = w_full;
    assign bus.fill_start   = r_fill_start;
    assign bus.tri_start    = r_tri_start;
    assign bus.fill_payload = r_cur_payload;
    assign bus.tri_payload  = r_cur_payload;
    assign bus.status_word  = r_status;
    assign bus.irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpu_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpu_command_scheduler
// Brief   : Directed, table-driven bench for gpu_command_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpu_command_scheduler;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [15:0] exp_done;

    gpu_command_scheduler_if bus ();

    gpu_command_scheduler #(
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        typ;
        logic [31:0] data;
        int          delay;
        logic        exp_fill;
        logic        exp_tri;
        logic [15:0] exp_done;
    } vec_t;

    vec_t vecs [4];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_cmd(input logic typ, input logic [31:0] data);
        bus.cmd_write = 1'b1;
        bus.cmd_type  = typ;
        bus.cmd_data  = data;
        cycle();
        bus.cmd_write = 1'b0;
    endtask

    task automatic pulse_done(input logic typ);
        if (typ) bus.tri_done = 1'b1;
        else     bus.fill_done = 1'b1;
        cycle();
        bus.tri_done  = 1'b0;
        bus.fill_done = 1'b0;
    endtask

    task automatic clear_status();
        bus.status_clear = 1'b1;
        cycle();
        bus.status_clear = 1'b0;
    endtask

    task automatic wait_start(input logic typ, input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = bus.fill_start || bus.tri_start;
        while (!seen && n < 40) begin
            cycle();
            n++;
            seen = bus.fill_start || bus.tri_start;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: no start within 40 cycles", name);
        end else if (bus.tri_start !== typ || bus.fill_start !== ~typ) begin
            bad++;
            $display("FAIL %s: got fill_start=%b tri_start=%b expected type %0d",
                     name, bus.fill_start, bus.tri_start, typ);
        end
    endtask

    initial begin
        int starts_seen;
        total = 0;
        bad   = 0;
        exp_done = '0;

        vecs[0] = '{1'b0, 32'h00FF00FF, 5,  1'b1, 1'b0, 16'd1};
        vecs[1] = '{1'b1, 32'hDEADBEEF, 0,  1'b0, 1'b1, 16'd2};
        vecs[2] = '{1'b0, 32'h12345678, 3,  1'b1, 1'b0, 16'd3};
        vecs[3] = '{1'b1, 32'h00000000, 10, 1'b0, 1'b1, 16'd4};

        reset            = 1'b1;
        bus.cmd_write    = 1'b0;
        bus.cmd_type     = 1'b0;
        bus.cmd_data     = '0;
        bus.status_clear = 1'b0;
        bus.fill_done    = 1'b0;
        bus.tri_done     = 1'b0;
        repeat (3) cycle();
        chk("reset_status", bus.status_word, 32'h0);
        chk("reset_full", {31'd0, bus.cmd_full}, 32'd0);
        chk("reset_irq", {31'd0, bus.irq}, 32'd0);
        chk("reset_payload", bus.fill_payload, 32'h0);
        reset = 1'b0;
        cycle();

        // Single commands: start two edges after the write, payload held, completion counted.
        for (int i = 0; i < 4; i++) begin
            write_cmd(vecs[i].typ, vecs[i].data);
            chk("busy_after_write", {31'd0, bus.status_word[0]}, 32'd1);
            cycle();
            chk("no_early_start", {30'd0, bus.fill_start, bus.tri_start}, 32'd0);
            cycle();
            chk("fill_start", {31'd0, bus.fill_start}, {31'd0, vecs[i].exp_fill});
            chk("tri_start", {31'd0, bus.tri_start}, {31'd0, vecs[i].exp_tri});
            chk("fill_payload", bus.fill_payload, vecs[i].data);
            chk("tri_payload", bus.tri_payload, vecs[i].data);
            chk("cur_type", {31'd0, bus.status_word[4]}, {31'd0, vecs[i].typ});
            cycle();
            chk("start_one_cycle", {30'd0, bus.fill_start, bus.tri_start}, 32'd0);
            repeat (vecs[i].delay) cycle();
            pulse_done(vecs[i].typ);
            chk("completed", {16'd0, bus.status_word[31:16]}, {16'd0, vecs[i].exp_done});
            chk("idle_after_done", {31'd0, bus.status_word[0]}, 32'd0);
            exp_done = vecs[i].exp_done;
        end

        // Overflow while the triangle engine is stalled.
        starts_seen = 0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_write = 1'b1;
            bus.cmd_type  = 1'b1;
            bus.cmd_data  = 32'hA0 + 32'(i);
            cycle();
            if (bus.tri_start || bus.fill_start) starts_seen++;
            if (i == 4) begin
                chk("full_at_4", {31'd0, bus.cmd_full}, 32'd1);
                chk("no_overflow_yet", {31'd0, bus.status_word[1]}, 32'd0);
            end
        end
        bus.cmd_write = 1'b0;
        chk("one_issued", 32'(starts_seen), 32'd1);
        chk("overflow_set", {31'd0, bus.status_word[1]}, 32'd1);
        chk("overflow_irq", {31'd0, bus.irq}, 32'd1);
        chk("fifo_count_4", {24'd0, bus.status_word[15:8]}, 32'd4);
        clear_status();
        chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
        chk("overflow_cleared", {31'd0, bus.status_word[1]}, 32'd0);
        chk("still_full", {31'd0, bus.cmd_full}, 32'd1);
        pulse_done(1'b1);
        exp_done++;
        for (int k = 0; k < 4; k++) begin
            wait_start(1'b1, "drain_start");
            chk("drain_payload", bus.tri_payload, 32'hA1 + 32'(k));
            pulse_done(1'b1);
            exp_done++;
            chk("drain_completed", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});
        end
        chk("drain_no_errors", {29'd0, bus.status_word[3:1]}, 32'd0);

        // Interleaved fill/tri/fill.
        write_cmd(1'b0, 32'h11111111);
        write_cmd(1'b1, 32'h22222222);
        write_cmd(1'b0, 32'h33333333);
        wait_start(1'b0, "mix_start0");
        chk("mix_payload0", bus.fill_payload, 32'h11111111);
        pulse_done(1'b0);
        wait_start(1'b1, "mix_start1");
        chk("mix_payload1", bus.tri_payload, 32'h22222222);
        pulse_done(1'b1);
        wait_start(1'b0, "mix_start2");
        chk("mix_payload2", bus.fill_payload, 32'h33333333);
        pulse_done(1'b0);
        exp_done = exp_done + 16'd3;
        chk("mix_completed", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});

        // Timeout after 16 cycles without done; queued command then issues.
        write_cmd(1'b0, 32'hAAAA0001);
        write_cmd(1'b0, 32'hAAAA0002);
        wait_start(1'b0, "to_start");
        repeat (15) cycle();
        chk("timeout_not_yet", {31'd0, bus.status_word[2]}, 32'd0);
        cycle();
        chk("timeout_set", {31'd0, bus.status_word[2]}, 32'd1);
        chk("timeout_irq", {31'd0, bus.irq}, 32'd1);
        chk("timeout_no_count", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});
        wait_start(1'b0, "after_timeout_start");
        chk("after_timeout_payload", bus.fill_payload, 32'hAAAA0002);
        pulse_done(1'b0);
        exp_done++;
        chk("after_timeout_completed", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});
        clear_status();
        chk("timeout_cleared", {31'd0, bus.irq}, 32'd0);

        // Wrong-engine done while waiting, and clear racing a new error.
        write_cmd(1'b0, 32'h55550000);
        wait_start(1'b0, "spur_start");
        pulse_done(1'b1);
        chk("spurious_set", {31'd0, bus.status_word[3]}, 32'd1);
        chk("spurious_still_busy", {31'd0, bus.status_word[0]}, 32'd1);
        chk("spurious_no_count", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});
        bus.status_clear = 1'b1;
        bus.tri_done     = 1'b1;
        cycle();
        bus.status_clear = 1'b0;
        bus.tri_done     = 1'b0;
        chk("error_beats_clear", {31'd0, bus.status_word[3]}, 32'd1);
        pulse_done(1'b0);
        exp_done++;
        chk("spur_completed", {16'd0, bus.status_word[31:16]}, {16'd0, exp_done});
        clear_status();
        chk("spurious_cleared", {31'd0, bus.irq}, 32'd0);
        pulse_done(1'b0);
        chk("idle_done_spurious", {31'd0, bus.status_word[3]}, 32'd1);
        clear_status();

        // Reset in WAIT with two queued commands.
        write_cmd(1'b1, 32'hBBBB0001);
        write_cmd(1'b1, 32'hBBBB0002);
        write_cmd(1'b1, 32'hBBBB0003);
        wait_start(1'b1, "rst_start");
        chk("rst_queued", {24'd0, bus.status_word[15:8]}, 32'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_status", bus.status_word, 32'h0);
        chk("rst_full", {31'd0, bus.cmd_full}, 32'd0);
        chk("rst_payload", bus.tri_payload, 32'h0);
        starts_seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.fill_start || bus.tri_start) starts_seen++;
        end
        chk("rst_no_starts", 32'(starts_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
